// File: rtl/kv_lookup_engine.sv
// Direct-mapped key table answering LOOKUP/INSERT/DELETE/CLEAR requests through a fixed
// three-stage pipeline, with same-index write-back forwarding and a valid-bit scrub walker.
module kv_lookup_engine #(
    parameter int KEY_SIZE    = 96,
    parameter int TABLE_DEPTH = 1024,
    localparam int IDX_W      = $clog2(TABLE_DEPTH)
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                busy,
    output logic [IDX_W:0]      entry_count
);
    localparam int NSLICE = (KEY_SIZE + IDX_W - 1) / IDX_W;
    localparam int PAD_W  = NSLICE * IDX_W;

    localparam logic [3:0] OP_LOOKUP = 4'b0001;
    localparam logic [3:0] OP_INSERT = 4'b0010;
    localparam logic [3:0] OP_DELETE = 4'b0100;
    localparam logic [3:0] OP_CLEAR  = 4'b1000;

    localparam logic [3:0] F_HIT     = 4'b0001;
    localparam logic [3:0] F_MISS    = 4'b0010;
    localparam logic [3:0] F_STORED  = 4'b0100;
    localparam logic [3:0] F_COLLIDE = 4'b1000;
    localparam logic [3:0] F_BUSY    = 4'b1111;
    localparam logic [3:0] F_ERR     = 4'b0000;

    localparam logic [IDX_W:0]   CNT_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TABLE_DEPTH - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_SCRUB} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     scrub_idx_q, scrub_idx_d;
    logic [IDX_W:0]       count_q, count_d;

    logic                 vld_p1_q, bsy_p1_q;
    logic [KEY_SIZE-1:0]  key_p1_q;
    logic [3:0]           flag_p1_q;
    logic [IDX_W-1:0]     idx_p1_q;

    logic                 vld_p2_q, bsy_p2_q;
    logic [KEY_SIZE-1:0]  key_p2_q;
    logic [3:0]           flag_p2_q;
    logic [IDX_W-1:0]     idx_p2_q;
    logic [KEY_SIZE:0]    ent_p2_q;

    logic                 out_valid_q;
    logic [3:0]           out_flag_q;

    logic [3:0]           res_flag;
    logic                 clear_go, key_hit, we;
    logic [IDX_W-1:0]     waddr;
    logic [KEY_SIZE:0]    wdata;

    // Entry layout: {valid, key}
    logic [KEY_SIZE:0]    mem [TABLE_DEPTH];

    function automatic logic [IDX_W-1:0] key_hash(input logic [KEY_SIZE-1:0] key);
        logic [PAD_W-1:0] padded;
        logic [IDX_W-1:0] h;
        padded = PAD_W'(key);
        h      = '0;
        for (int s = 0; s < NSLICE; s++) h = h ^ padded[s*IDX_W +: IDX_W];
        return h;
    endfunction

    always_comb begin
        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        case (state_q)
            ST_RUN: if (clear_go) state_d = ST_SCRUB;
            default: begin
                scrub_idx_d = scrub_idx_q + IDX_ONE;
                if (scrub_idx_q == IDX_MAX) state_d = ST_RUN;
            end
        endcase
    end

    // Stage 3: compare against the (forwarded) slot, decide result and write-back.
    // Scrub owns the write port; nothing non-busy reaches here while scrubbing.
    always_comb begin
        res_flag = F_ERR;
        clear_go = 1'b0;
        count_d  = count_q;
        we       = 1'b0;
        waddr    = idx_p2_q;
        wdata    = '0;
        key_hit  = ent_p2_q[KEY_SIZE] && (ent_p2_q[KEY_SIZE-1:0] == key_p2_q);
        if (state_q != ST_RUN) begin
            we    = 1'b1;
            waddr = scrub_idx_q;
        end else if (vld_p2_q && !bsy_p2_q) begin
            case (flag_p2_q)
                OP_LOOKUP: res_flag = key_hit ? F_HIT : F_MISS;
                OP_INSERT: begin
                    if (!ent_p2_q[KEY_SIZE]) begin
                        we       = 1'b1;
                        wdata    = {1'b1, key_p2_q};
                        count_d  = count_q + CNT_ONE;
                        res_flag = F_STORED;
                    end else begin
                        res_flag = key_hit ? F_STORED : F_COLLIDE;
                    end
                end
                OP_DELETE: begin
                    if (key_hit) begin
                        we       = 1'b1;
                        wdata    = {1'b0, key_p2_q};
                        count_d  = count_q - CNT_ONE;
                        res_flag = F_HIT;
                    end else begin
                        res_flag = F_MISS;
                    end
                end
                OP_CLEAR: begin
                    clear_go = 1'b1;
                    count_d  = '0;
                    res_flag = F_STORED;
                end
                default: res_flag = F_ERR;
            endcase
        end
        if (bsy_p2_q) res_flag = F_BUSY;
    end

    // A CLEAR in stage 3 marks everything behind it (S1, S2 and the request being captured) busy.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q     <= ST_INIT;
            scrub_idx_q <= '0;
            count_q     <= '0;
            vld_p1_q    <= 1'b0;
            bsy_p1_q    <= 1'b1;
            vld_p2_q    <= 1'b0;
            bsy_p2_q    <= 1'b1;
            out_valid_q <= 1'b0;
            out_flag_q  <= F_ERR;
        end else begin
            state_q     <= state_d;
            scrub_idx_q <= scrub_idx_d;
            count_q     <= count_d;
            vld_p1_q    <= in_valid;
            bsy_p1_q    <= (state_q != ST_RUN) || clear_go;
            vld_p2_q    <= vld_p1_q;
            bsy_p2_q    <= bsy_p1_q || clear_go;
            out_valid_q <= vld_p2_q;
            out_flag_q  <= vld_p2_q ? res_flag : F_ERR;
        end
    end

    // Stage 1 -> 2: synchronous read; a write landing on the same edge is forwarded.
    always_ff @(posedge clk156) begin
        key_p1_q  <= in_key;
        flag_p1_q <= in_flag;
        idx_p1_q  <= key_hash(in_key);
        key_p2_q  <= key_p1_q;
        flag_p2_q <= flag_p1_q;
        idx_p2_q  <= idx_p1_q;
        ent_p2_q  <= (we && (waddr == idx_p1_q)) ? wdata : mem[idx_p1_q];
        if (we) mem[waddr] <= wdata;
    end

    assign out_valid   = out_valid_q;
    assign out_flag    = out_flag_q;
    assign busy        = (state_q != ST_RUN);
    assign entry_count = count_q;

endmodule
